if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and memory (slave).
// One request may be outstanding at a time; the response comes back on rvalid.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory fetcher feeding a 2-entry prefetch FIFO
// that drains into the IF/ID pipeline register, with branch redirect and stall handling.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  if_fetch_unit_if.master    imem,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc_plus4,
  output logic [31:0]        if_id_inst
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic [31:0]        req_addr_reg;
  logic [31:0]        fifo_pc4_reg  [QDEPTH];
  logic [31:0]        fifo_inst_reg [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W:0]     occupancy;
  logic               slot_free;
  logic               push;
  logic               pop;

  // A request in flight (WAIT) already owns a FIFO slot for its response.
  assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, (state_reg == WAIT)};
  assign slot_free = occupancy < (CNT_W + 1)'(QDEPTH);

  assign imem.imem_req  = (state_reg == REQ);
  assign imem.imem_addr = fetch_pc_reg;

  assign pop = !redirect && !stall && (count_reg != '0);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    push          = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!redirect && slot_free) state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          state_next = imem.imem_ack ? DROP : IDLE;
        end else if (imem.imem_ack) begin
          state_next    = WAIT;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          state_next = IDLE;
          push       = !redirect;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) fetch_pc_next = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      req_addr_reg   <= RESET_PC;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      if_id_valid    <= 1'b0;
      if_id_inst     <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (state_reg == REQ && imem.imem_ack) req_addr_reg <= fetch_pc_reg;

      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        if (push && !pop) count_reg <= count_reg + CNT_W'(1);
        else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
      end

      // Redirect wins over stall; an empty FIFO inserts a nop bubble but keeps the old PC+4.
      if (redirect) begin
        if_id_valid <= 1'b0;
        if_id_inst  <= 32'd0;
      end else if (!stall) begin
        if (count_reg != '0) begin
          if_id_valid    <= 1'b1;
          if_id_pc_plus4 <= fifo_pc4_reg[rd_ptr_reg];
          if_id_inst     <= fifo_inst_reg[rd_ptr_reg];
        end else begin
          if_id_valid <= 1'b0;
          if_id_inst  <= 32'd0;
        end
      end
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc4_reg[wr_ptr_reg]  <= req_addr_reg + 32'd4;
      fifo_inst_reg[wr_ptr_reg] <= imem.imem_rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a behavioural memory plus an in-order instruction-stream
// model (expected PC sequence, redirect epochs, slot ownership) checks every cycle.
module tb_if_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem          (bus),
    .if_id_valid   (if_id_valid),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_inst    (if_id_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus controls
  logic        ctl_reset, ctl_redirect, ctl_stall;
  logic [31:0] ctl_rpc;

  // memory model
  logic        mem_busy;
  int          mem_rv_cnt;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          ack_delay, rv_lat;
  logic        spurious_en;

  // instruction-stream model
  logic [31:0] exp_req_addr, exp_next;
  logic [31:0] m_pc4, m_inst;
  logic        m_valid, m_pc4_known;
  logic        dut_outst;
  int          owned;
  int          edge_idx, idle_cnt, n_entries;
  int          entry_edges[$];
  logic [31:0] ack_q[$];
  logic [31:0] last_entry_pc4;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic        acked, rv, req_pre;
    logic [31:0] addr_pre;
    reset       = ctl_reset;
    redirect    = ctl_redirect;
    redirect_pc = ctl_rpc;
    stall       = ctl_stall;
    rv    = 1'b0;
    acked = 1'b0;
    bus.imem_rdata = $urandom;
    if (mem_busy && mem_rv_cnt == 0) begin
      rv = 1'b1;
      bus.imem_rdata = inst_of(mem_addr);
    end else if (!mem_busy && spurious_en && $urandom_range(0, 15) == 0) begin
      rv = 1'b1;
    end
    req_pre  = bus.imem_req;
    addr_pre = bus.imem_addr;
    if (req_pre === 1'b1 && !mem_busy && !ctl_reset && mem_wait >= ack_delay) acked = 1'b1;
    bus.imem_ack    = acked;
    bus.imem_rvalid = rv;
    if (!ctl_reset && req_pre === 1'b1) begin
      check("req_addr", addr_pre, exp_req_addr);
      check("req_slot_free", 32'(owned < 2), 32'd1);
      check("req_single_outstanding", {31'd0, dut_outst}, 32'd0);
    end

    @(posedge clk);

    if (mem_busy) begin
      if (rv) mem_busy = 1'b0;
      else    mem_rv_cnt--;
    end
    if (acked) begin
      mem_busy   = 1'b1;
      mem_rv_cnt = rv_lat - 1;
      mem_addr   = addr_pre;
      ack_q.push_back(addr_pre);
    end
    mem_wait = (ctl_reset || req_pre !== 1'b1 || acked) ? 0 : mem_wait + 1;

    if (ctl_reset)  dut_outst = 1'b0;
    else if (acked) dut_outst = 1'b1;
    else if (rv)    dut_outst = 1'b0;

    if (ctl_reset)         exp_req_addr = RPC;
    else if (ctl_redirect) exp_req_addr = {ctl_rpc[31:2], 2'b00};
    else if (acked)        exp_req_addr = exp_req_addr + 32'd4;

    if (ctl_reset || ctl_redirect) owned = 0;
    else if (acked)                owned++;

    #1;

    if (ctl_reset) begin
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_inst", if_id_inst, 32'd0);
      check("rst_pc4", if_id_pc_plus4, 32'd0);
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check("rst_addr", bus.imem_addr, RPC);
      m_valid = 1'b0; m_inst = 32'd0; m_pc4 = 32'd0; m_pc4_known = 1'b1;
      exp_next = RPC + 32'd4;
      edge_idx = 0; idle_cnt = 0;
      entry_edges.delete();
    end else begin
      edge_idx++;
      if (ctl_redirect) begin
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_inst", if_id_inst, 32'd0);
        m_valid = 1'b0; m_inst = 32'd0; m_pc4_known = 1'b0;
        exp_next = {ctl_rpc[31:2], 2'b00} + 32'd4;
        idle_cnt = 0;
      end else if (ctl_stall) begin
        check("hold_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("hold_inst", if_id_inst, m_inst);
        if (m_pc4_known) check("hold_pc4", if_id_pc_plus4, m_pc4);
      end else if (if_id_valid === 1'b1) begin
        check("entry_pc4", if_id_pc_plus4, exp_next);
        check("entry_inst", if_id_inst, inst_of(exp_next - 32'd4));
        $display("entry %0d: pc_plus4=%h inst=%h edge=%0d", n_entries, if_id_pc_plus4, if_id_inst, edge_idx);
        m_valid = 1'b1; m_pc4 = exp_next; m_inst = inst_of(exp_next - 32'd4); m_pc4_known = 1'b1;
        last_entry_pc4 = if_id_pc_plus4;
        entry_edges.push_back(edge_idx);
        exp_next = exp_next + 32'd4;
        owned--; n_entries++; idle_cnt = 0;
      end else begin
        check("bubble_inst", if_id_inst, 32'd0);
        if (m_pc4_known) check("bubble_pc4", if_id_pc_plus4, m_pc4);
        m_valid = 1'b0; m_inst = 32'd0;
        idle_cnt++;
        if (idle_cnt >= 40) begin
          check("liveness_idle_cycles", 32'(idle_cnt), 32'd0);
          idle_cnt = 0;
        end
      end
    end
  endtask

  initial begin
    int          found, cur, e0, e1, e2;
    logic [31:0] a0;
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    ctl_reset = 1'b1; ctl_redirect = 1'b0; ctl_stall = 1'b0; ctl_rpc = 32'd0;
    mem_busy = 1'b0; mem_rv_cnt = 0; mem_addr = 32'd0; mem_wait = 0;
    ack_delay = 0; rv_lat = 1; spurious_en = 1'b0;
    exp_req_addr = RPC; exp_next = RPC + 32'd4;
    m_pc4 = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_pc4_known = 1'b1;
    dut_outst = 1'b0; owned = 0; edge_idx = 0; idle_cnt = 0; n_entries = 0;
    last_entry_pc4 = 32'd0;

    // reset, then zero-wait streaming: entries at edges 4, 7, 10
    repeat (3) cycle();
    ctl_reset = 1'b0;
    repeat (12) cycle();
    e0 = (entry_edges.size() > 0) ? entry_edges[0] : -1;
    e1 = (entry_edges.size() > 1) ? entry_edges[1] : -1;
    e2 = (entry_edges.size() > 2) ? entry_edges[2] : -1;
    check("first_valid_edge", 32'(e0), 32'd4);
    check("second_valid_edge", 32'(e1), 32'd7);
    check("third_valid_edge", 32'(e2), 32'd10);

    // stall 10 cycles: frozen IF/ID, fetching stops with FIFO full, then drains in order
    ctl_stall = 1'b1;
    repeat (10) cycle();
    check("stall_req_stopped", {31'd0, bus.imem_req}, 32'd0);
    ctl_stall = 1'b0;
    cycle();
    check("drain_first_valid", {31'd0, if_id_valid}, 32'd1);
    cycle();
    check("drain_second_valid", {31'd0, if_id_valid}, 32'd1);

    // redirect to 0x2003 while waiting for a response
    rv_lat = 3;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (dut_outst && mem_busy && mem_rv_cnt > 0) begin found = 1; break; end
      cycle();
    end
    check("wait_state_reached", 32'(found), 32'd1);
    ctl_redirect = 1'b1; ctl_rpc = 32'h0000_2003;
    cycle();
    ctl_redirect = 1'b0;
    ack_q.delete();
    for (int i = 0; i < 60 && ack_q.size() == 0; i++) cycle();
    a0 = (ack_q.size() > 0) ? ack_q[0] : 32'hDEAD_BEEF;
    check("redir_wait_next_addr", a0, 32'h0000_2000);
    cur = n_entries;
    for (int i = 0; i < 60 && n_entries == cur; i++) cycle();
    check("redir_wait_first_pc4", last_entry_pc4, 32'h0000_2004);

    // slow-ack memory: redirect while request is pending withdraws it
    ack_delay = 3; rv_lat = 1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.imem_req === 1'b1 && mem_wait == 1 && !mem_busy) begin found = 1; break; end
      cycle();
    end
    check("req_state_reached", 32'(found), 32'd1);
    ctl_redirect = 1'b1; ctl_rpc = 32'h0000_3000;
    cycle();
    ctl_redirect = 1'b0;
    check("req_withdrawn", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) cycle();
    check("withdraw_next_addr", bus.imem_addr, 32'h0000_3000);

    // address wrap at the top of the address space
    ack_delay = 0;
    ctl_redirect = 1'b1; ctl_rpc = 32'hFFFF_FFFC;
    cycle();
    ctl_redirect = 1'b0;
    ack_q.delete();
    cur = n_entries;
    for (int i = 0; i < 60 && n_entries == cur; i++) cycle();
    check("wrap_entry_pc4", last_entry_pc4, 32'h0000_0000);
    for (int i = 0; i < 60 && ack_q.size() < 2; i++) cycle();
    a0 = (ack_q.size() > 1) ? ack_q[1] : 32'hDEAD_BEEF;
    check("wrap_next_addr", a0, 32'h0000_0000);

    // reset while waiting; the response lands the following cycle and must be ignored
    rv_lat = 2;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (dut_outst && mem_busy && mem_rv_cnt == 1) begin found = 1; break; end
      cycle();
    end
    check("wait_before_reset", 32'(found), 32'd1);
    ctl_reset = 1'b1;
    cycle();
    ctl_reset = 1'b0;
    cycle();
    check("post_reset_valid", {31'd0, if_id_valid}, 32'd0);
    cur = n_entries;
    for (int i = 0; i < 60 && n_entries == cur; i++) cycle();
    check("post_reset_first_pc4", last_entry_pc4, RPC + 32'd4);

    // randomized traffic
    spurious_en = 1'b1;
    cur = n_entries;
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 0) begin
        ack_delay = $urandom_range(0, 3);
        rv_lat    = $urandom_range(1, 3);
      end
      ctl_stall    = ($urandom_range(0, 9) < 3);
      ctl_redirect = ($urandom_range(0, 39) == 0);
      ctl_rpc      = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
      cycle();
    end
    ctl_stall = 1'b0; ctl_redirect = 1'b0;
    repeat (20) cycle();
    check("random_progress", 32'((n_entries - cur) > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
